scarv_cop_insn_buf: RTL and testbench
=====================================

SCARV_COP_INSN_BUF -- requirements
Module: scarv_cop_insn_buf

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning instruction buffer entries (power of 2, range 2..16).
REQ-002 SHALL have parameter XLEN, default 32, meaning instruction-word and rs1-data width.
REQ-003 SHALL have port g_clk, input, 1 bit, the single global clock; all state updates on its rising edge.
REQ-004 SHALL have port g_reset, input, 1 bit; reset is synchronous and active-high.
REQ-005 SHALL have port cpu_insn_req, input, 1 bit: CPU offers an instruction.
REQ-006 SHALL have port cop_insn_ack, output, 1 bit: buffer accepts the offer.
REQ-007 SHALL have port cpu_abort_req, input, 1 bit: flush un-issued instructions.
REQ-008 SHALL have port cpu_insn_enc, input, XLEN bits: encoded instruction.
REQ-009 SHALL have port cpu_rs1, input, XLEN bits: rs1 source data.
REQ-010 SHALL have port exe_valid, output, 1 bit: head entry presented to execute stage.
REQ-011 SHALL have port exe_ready, input, 1 bit: execute stage takes head entry.
REQ-012 SHALL have ports exe_insn and exe_rs1, outputs, XLEN bits each: head entry contents.
REQ-013 SHALL have port exe_rsp_valid, input, 1 bit: execute result available.
REQ-014 SHALL have port exe_rsp_ready, output, 1 bit: result accepted.
REQ-015 SHALL have ports exe_wen (1), exe_waddr (5), exe_wdata (XLEN), exe_result (3), all inputs: execute result fields.
REQ-016 SHALL have ports cop_wen (1), cop_waddr (5), cop_wdata (XLEN), cop_result (3), all outputs: registered response to the CPU.
REQ-017 SHALL have port cop_insn_rsp, output, 1 bit: response valid.
REQ-018 SHALL have port cpu_insn_ack, input, 1 bit: CPU consumes the response.
REQ-019 SHALL have port buf_count, output, $clog2(DEPTH)+1 bits: occupied entries.
REQ-020 SHALL have port cop_busy, output, 1 bit: buf_count != 0, or an instruction is in execute, or cop_insn_rsp is high.

Function
REQ-021 Push SHALL occur when cpu_insn_req && cop_insn_ack in the same cycle; cop_insn_ack = !full_q && !cpu_abort_req && !g_reset, with full_q registered.
REQ-022 Issue SHALL occur when exe_valid && exe_ready; exe_valid = (buf_count != 0); exe_insn/exe_rs1 SHALL be the FIFO head with zero added latency.
REQ-023 Simultaneous push and issue SHALL leave buf_count unchanged; read and write pointers SHALL wrap modulo DEPTH.
REQ-024 Push when full SHALL be impossible: ack is low; a same-cycle issue from full SHALL NOT enable a push that cycle.
REQ-025 Response path SHALL be a two-state FSM (RSP_IDLE, RSP_HOLD): RSP_IDLE -> RSP_HOLD on a result transfer; RSP_HOLD -> RSP_IDLE on cpu_insn_ack with no new transfer; RSP_HOLD -> RSP_HOLD on cpu_insn_ack with a same-cycle new transfer.
REQ-026 exe_rsp_ready SHALL equal !cop_insn_rsp || cpu_insn_ack, giving back-to-back responses at one per cycle.
REQ-027 cop_wen, cop_waddr, cop_wdata and cop_result SHALL load only on a result transfer and SHALL hold stable while cop_insn_rsp is high and cpu_insn_ack is low.
REQ-028 Result latency SHALL be one cycle: exe result at cycle N produces cop_insn_rsp high at N+1.
REQ-029 cpu_abort_req SHALL set buf_count to 0 next cycle and SHALL drop any same-cycle push.
REQ-030 Abort SHALL block issue that cycle: exe_valid is forced low while cpu_abort_req is high.
REQ-031 Abort SHALL NOT affect an instruction already in execute or a pending response; that response SHALL still be delivered.
REQ-032 buf_count SHALL never exceed DEPTH.

Reset
REQ-033 When g_reset is high at a clock edge, the next state SHALL be: pointers = 0, buf_count = 0, full_q = 0, FSM = RSP_IDLE.
REQ-034 After that reset edge, the outputs SHALL be: cop_insn_rsp = 0, cop_wen = 0, cop_waddr = 0, cop_wdata = 0, cop_result = 0, exe_valid = 0, cop_busy = 0.
REQ-035 Reset mid-operation SHALL discard all buffered entries and any pending response without a handshake.
REQ-036 cop_insn_ack SHALL be low while g_reset is high.
REQ-037 The FIFO storage array SHALL NOT be reset.

Structure
REQ-038 Result-code constants (3-bit) and the FSM state encodings SHALL reside in shared package scarv_cop_pkg.
REQ-039 FIFO storage and pointers SHALL be one sub-module, scarv_cop_fifo (parameters DEPTH, WIDTH = 2*XLEN).
REQ-040 Response FSM and registers SHALL be in scarv_cop_insn_buf itself.

Verification
REQ-041 Reset, then push insn 0x0000_000B with rs1 0x1234_5678 while exe_ready = 1 -> exe_valid high the cycle after the push with exe_insn = 0x0000_000B; buf_count returns to 0.
REQ-042 DEPTH = 4, exe_ready = 0, push 5 times -> first 4 are acked, buf_count = 4, cop_insn_ack low on the 5th; one issue then re-enables ack the following cycle.
REQ-043 exe result wen = 1, waddr = 5, wdata = 0xDEAD_BEEF with cpu_insn_ack = 0 for 3 cycles -> cop_insn_rsp high for 3 cycles with fields stable; exe_rsp_ready low throughout.
REQ-044 3 entries buffered, one in execute, assert cpu_abort_req -> buf_count = 0 next cycle; the in-execute result is still delivered via cop_insn_rsp.
REQ-045 Continuous exe_rsp_valid with cpu_insn_ack tied high -> one response per cycle with no bubbles.
REQ-046 Assert g_reset while cop_insn_rsp is high and buf_count = 2 -> all outputs take their reset values the next cycle.

Source files
------------

// File: rtl/scarv_cop_pkg.sv
// Shared definitions for the SCARV coprocessor instruction buffer.
// Contains:
//   - 3-bit result codes carried on exe_result / cop_result
//   - encoding of the two-state response FSM
package scarv_cop_pkg;

    localparam logic [2:0] COP_RESULT_SUCCESS = 3'd0;
    localparam logic [2:0] COP_RESULT_ABORT   = 3'd1;
    localparam logic [2:0] COP_RESULT_BADINS  = 3'd2;
    localparam logic [2:0] COP_RESULT_LSUERR  = 3'd3;
    localparam logic [2:0] COP_RESULT_STALL   = 3'd4;

    typedef enum logic {
        RSP_IDLE = 1'b0,
        RSP_HOLD = 1'b1
    } rsp_state_t;

endpackage

// File: rtl/scarv_cop_fifo.sv
// Synchronous FIFO holding {instruction, rs1} pairs for the coprocessor.
// Ports:
//   g_clk, g_reset : clock and synchronous active-high reset
//   push, wdata    : write one entry (caller guarantees !full)
//   pop            : drop head entry (caller guarantees count != 0)
//   flush          : discard every entry; overrides push/pop
//   rdata          : head entry, combinational from storage
//   count, full    : occupancy and registered full flag
module scarv_cop_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       g_clk,
    input  logic                       g_reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_nxt;

    // Storage has no reset; only the pointers/count define validity.
    always_ff @(posedge g_clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

    assign rdata = mem[rd_ptr];

endmodule

// File: rtl/scarv_cop_insn_buf.sv
// Coprocessor instruction buffer: queues CPU instructions for the execute
// stage and returns execute results to the CPU through a registered
// response stage.
// Ports:
//   g_clk, g_reset              : clock, synchronous active-high reset
//   cpu_insn_req/cop_insn_ack   : instruction offer / accept
//   cpu_abort_req               : flush un-issued instructions
//   cpu_insn_enc, cpu_rs1       : instruction and rs1 data
//   exe_valid/exe_ready         : head entry to execute stage
//   exe_insn, exe_rs1           : head entry contents
//   exe_rsp_valid/exe_rsp_ready : execute result handshake
//   exe_wen..exe_result         : execute result fields
//   cop_wen..cop_result         : registered response fields
//   cop_insn_rsp/cpu_insn_ack   : response valid / consumed
//   buf_count, cop_busy         : occupancy and activity status
//
// Response FSM:
//   state    | meaning
//   RSP_IDLE | no response pending, result path open
//   RSP_HOLD | cop_* fields valid, waiting for cpu_insn_ack
module scarv_cop_insn_buf
    import scarv_cop_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic                   cpu_insn_req,
    output logic                   cop_insn_ack,
    input  logic                   cpu_abort_req,
    input  logic [XLEN-1:0]        cpu_insn_enc,
    input  logic [XLEN-1:0]        cpu_rs1,
    output logic                   exe_valid,
    input  logic                   exe_ready,
    output logic [XLEN-1:0]        exe_insn,
    output logic [XLEN-1:0]        exe_rs1,
    input  logic                   exe_rsp_valid,
    output logic                   exe_rsp_ready,
    input  logic                   exe_wen,
    input  logic [4:0]             exe_waddr,
    input  logic [XLEN-1:0]        exe_wdata,
    input  logic [2:0]             exe_result,
    output logic                   cop_wen,
    output logic [4:0]             cop_waddr,
    output logic [XLEN-1:0]        cop_wdata,
    output logic [2:0]             cop_result,
    output logic                   cop_insn_rsp,
    input  logic                   cpu_insn_ack,
    output logic [$clog2(DEPTH):0] buf_count,
    output logic                   cop_busy
);

    logic            full_q;
    logic            push;
    logic            issue;
    logic            rsp_xfer;
    logic            in_exe_q;
    logic [2*XLEN-1:0] head;
    rsp_state_t      rsp_state;
    rsp_state_t      rsp_state_nxt;

    // full_q is registered, so an issue from full cannot open ack that cycle.
    assign cop_insn_ack = !full_q && !cpu_abort_req && !g_reset;
    assign push         = cpu_insn_req && cop_insn_ack;
    assign exe_valid    = (buf_count != '0) && !cpu_abort_req;
    assign issue        = exe_valid && exe_ready;

    scarv_cop_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*XLEN)
    ) u_fifo (
        .g_clk   (g_clk),
        .g_reset (g_reset),
        .push    (push),
        .pop     (issue),
        .flush   (cpu_abort_req),
        .wdata   ({cpu_insn_enc, cpu_rs1}),
        .rdata   (head),
        .count   (buf_count),
        .full    (full_q)
    );

    assign exe_insn = head[2*XLEN-1:XLEN];
    assign exe_rs1  = head[XLEN-1:0];

    // Tracks an issued instruction whose result has not yet come back;
    // abort leaves it alone so its result is still delivered.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            in_exe_q <= 1'b0;
        end else if (issue) begin
            in_exe_q <= 1'b1;
        end else if (rsp_xfer) begin
            in_exe_q <= 1'b0;
        end
    end

    assign rsp_xfer = exe_rsp_valid && exe_rsp_ready;

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            rsp_state <= RSP_IDLE;
        end else begin
            rsp_state <= rsp_state_nxt;
        end
    end

    always_comb begin
        rsp_state_nxt = rsp_state;
        case (rsp_state)
            RSP_IDLE: if (rsp_xfer) rsp_state_nxt = RSP_HOLD;
            RSP_HOLD: if (cpu_insn_ack && !rsp_xfer) rsp_state_nxt = RSP_IDLE;
            default:  rsp_state_nxt = RSP_IDLE;
        endcase
    end

    always_comb begin
        cop_insn_rsp  = (rsp_state == RSP_HOLD);
        exe_rsp_ready = (rsp_state == RSP_IDLE) || cpu_insn_ack;
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            cop_wen    <= 1'b0;
            cop_waddr  <= '0;
            cop_wdata  <= '0;
            cop_result <= COP_RESULT_SUCCESS;
        end else if (rsp_xfer) begin
            cop_wen    <= exe_wen;
            cop_waddr  <= exe_waddr;
            cop_wdata  <= exe_wdata;
            cop_result <= exe_result;
        end
    end

    assign cop_busy = (buf_count != '0) || in_exe_q || cop_insn_rsp;

endmodule

// File: tb/tb_scarv_cop_insn_buf.sv
module tb_scarv_cop_insn_buf;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic              g_clk = 1'b0;
    logic              g_reset;
    logic              cpu_insn_req;
    logic              cop_insn_ack;
    logic              cpu_abort_req;
    logic [XLEN-1:0]   cpu_insn_enc;
    logic [XLEN-1:0]   cpu_rs1;
    logic              exe_valid;
    logic              exe_ready;
    logic [XLEN-1:0]   exe_insn;
    logic [XLEN-1:0]   exe_rs1;
    logic              exe_rsp_valid;
    logic              exe_rsp_ready;
    logic              exe_wen;
    logic [4:0]        exe_waddr;
    logic [XLEN-1:0]   exe_wdata;
    logic [2:0]        exe_result;
    logic              cop_wen;
    logic [4:0]        cop_waddr;
    logic [XLEN-1:0]   cop_wdata;
    logic [2:0]        cop_result;
    logic              cop_insn_rsp;
    logic              cpu_insn_ack;
    logic [$clog2(DEPTH):0] buf_count;
    logic              cop_busy;

    int checks = 0;
    int errors = 0;

    always #5 g_clk = ~g_clk;

    scarv_cop_insn_buf #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .g_clk         (g_clk),
        .g_reset       (g_reset),
        .cpu_insn_req  (cpu_insn_req),
        .cop_insn_ack  (cop_insn_ack),
        .cpu_abort_req (cpu_abort_req),
        .cpu_insn_enc  (cpu_insn_enc),
        .cpu_rs1       (cpu_rs1),
        .exe_valid     (exe_valid),
        .exe_ready     (exe_ready),
        .exe_insn      (exe_insn),
        .exe_rs1       (exe_rs1),
        .exe_rsp_valid (exe_rsp_valid),
        .exe_rsp_ready (exe_rsp_ready),
        .exe_wen       (exe_wen),
        .exe_waddr     (exe_waddr),
        .exe_wdata     (exe_wdata),
        .exe_result    (exe_result),
        .cop_wen       (cop_wen),
        .cop_waddr     (cop_waddr),
        .cop_wdata     (cop_wdata),
        .cop_result    (cop_result),
        .cop_insn_rsp  (cop_insn_rsp),
        .cpu_insn_ack  (cpu_insn_ack),
        .buf_count     (buf_count),
        .cop_busy      (cop_busy)
    );

    task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; sampling happens 1ns after the rising edge.
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    initial begin
        g_reset       = 1'b1;
        cpu_insn_req  = 1'b0;
        cpu_abort_req = 1'b0;
        cpu_insn_enc  = '0;
        cpu_rs1       = '0;
        exe_ready     = 1'b0;
        exe_rsp_valid = 1'b0;
        exe_wen       = 1'b0;
        exe_waddr     = '0;
        exe_wdata     = '0;
        exe_result    = '0;
        cpu_insn_ack  = 1'b0;
        tick();
        tick();

        // Reset state, ack suppressed while reset is high
        chk("rst_rsp",    64'(cop_insn_rsp), 64'd0);
        chk("rst_wen",    64'(cop_wen),      64'd0);
        chk("rst_wdata",  64'(cop_wdata),    64'd0);
        chk("rst_valid",  64'(exe_valid),    64'd0);
        chk("rst_count",  64'(buf_count),    64'd0);
        chk("rst_busy",   64'(cop_busy),     64'd0);
        cpu_insn_req = 1'b1;
        #1;
        chk("rst_ack_low", 64'(cop_insn_ack), 64'd0);
        cpu_insn_req = 1'b0;
        g_reset = 1'b0;
        tick();

        // Single push then issue with exe_ready high
        cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'h0000_000B;
        cpu_rs1      = 32'h1234_5678;
        exe_ready    = 1'b1;
        #1;
        chk("p1_ack", 64'(cop_insn_ack), 64'd1);
        tick();
        cpu_insn_req = 1'b0;
        chk("p1_valid", 64'(exe_valid), 64'd1);
        chk("p1_insn",  64'(exe_insn),  64'h0000_000B);
        chk("p1_rs1",   64'(exe_rs1),   64'h1234_5678);
        chk("p1_count", 64'(buf_count), 64'd1);
        tick();
        exe_ready = 1'b0;
        chk("p1_count0", 64'(buf_count), 64'd0);
        chk("p1_valid0", 64'(exe_valid), 64'd0);
        chk("p1_busy_exe", 64'(cop_busy), 64'd1);

        // Held response: fields stable while new result offered
        exe_rsp_valid = 1'b1;
        exe_wen       = 1'b1;
        exe_waddr     = 5'd5;
        exe_wdata     = 32'hDEAD_BEEF;
        exe_result    = 3'd2;
        #1;
        chk("h_ready_idle", 64'(exe_rsp_ready), 64'd1);
        tick();
        exe_wen   = 1'b0;
        exe_waddr = 5'd7;
        exe_wdata = 32'h1111_1111;
        exe_result = 3'd4;
        for (int i = 0; i < 3; i++) begin
            chk("h_rsp",    64'(cop_insn_rsp),  64'd1);
            chk("h_wen",    64'(cop_wen),       64'd1);
            chk("h_waddr",  64'(cop_waddr),     64'd5);
            chk("h_wdata",  64'(cop_wdata),     64'hDEAD_BEEF);
            chk("h_result", 64'(cop_result),    64'd2);
            chk("h_ready",  64'(exe_rsp_ready), 64'd0);
            if (i < 2) tick();
        end
        exe_rsp_valid = 1'b0;
        cpu_insn_ack  = 1'b1;
        #1;
        chk("h_ready_ack", 64'(exe_rsp_ready), 64'd1);
        tick();
        cpu_insn_ack = 1'b0;
        chk("h_rsp_done", 64'(cop_insn_rsp), 64'd0);
        chk("h_busy_done", 64'(cop_busy),    64'd0);

        // Fill to DEPTH, fifth offer refused
        cpu_insn_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cpu_insn_enc = 32'h100 + 32'(i);
            cpu_rs1      = 32'(i);
            #1;
            chk("f_ack", 64'(cop_insn_ack), (i < 4) ? 64'd1 : 64'd0);
            tick();
        end
        chk("f_count4", 64'(buf_count), 64'd4);
        chk("f_head",   64'(exe_insn),  64'h100);
        cpu_insn_enc = 32'h104;
        cpu_rs1      = 32'd4;
        exe_ready    = 1'b1;
        #1;
        chk("f_ack_issue_full", 64'(cop_insn_ack), 64'd0);
        tick();
        exe_ready = 1'b0;
        chk("f_count3", 64'(buf_count), 64'd3);
        chk("f_head2",  64'(exe_insn),  64'h101);
        #1;
        chk("f_ack_reopen", 64'(cop_insn_ack), 64'd1);
        tick();
        cpu_insn_req = 1'b0;
        chk("f_count4b", 64'(buf_count), 64'd4);

        // Issue one more (3 buffered, one in execute), then abort
        exe_ready = 1'b1;
        tick();
        chk("a_count3", 64'(buf_count), 64'd3);
        chk("a_head",   64'(exe_insn),  64'h102);
        cpu_abort_req = 1'b1;
        cpu_insn_req  = 1'b1;
        cpu_insn_enc  = 32'h1FF;
        #1;
        chk("a_valid_blk", 64'(exe_valid),    64'd0);
        chk("a_ack_blk",   64'(cop_insn_ack), 64'd0);
        tick();
        cpu_abort_req = 1'b0;
        cpu_insn_req  = 1'b0;
        exe_ready     = 1'b0;
        chk("a_count0", 64'(buf_count), 64'd0);
        chk("a_valid0", 64'(exe_valid), 64'd0);
        chk("a_busy",   64'(cop_busy),  64'd1);
        exe_rsp_valid = 1'b1;
        exe_wen       = 1'b0;
        exe_waddr     = 5'd3;
        exe_wdata     = 32'h0000_CAFE;
        exe_result    = 3'd1;
        tick();
        exe_rsp_valid = 1'b0;
        chk("a_rsp",    64'(cop_insn_rsp), 64'd1);
        chk("a_waddr",  64'(cop_waddr),    64'd3);
        chk("a_wdata",  64'(cop_wdata),    64'h0000_CAFE);
        chk("a_result", 64'(cop_result),   64'd1);
        cpu_insn_ack = 1'b1;
        tick();
        cpu_insn_ack = 1'b0;
        chk("a_rsp_done", 64'(cop_insn_rsp), 64'd0);
        chk("a_busy_done", 64'(cop_busy),    64'd0);

        // Push after flush lands at the correct head
        cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'hAA;
        cpu_rs1      = 32'hBB;
        tick();
        cpu_insn_req = 1'b0;
        chk("w_count", 64'(buf_count), 64'd1);
        chk("w_head",  64'(exe_insn),  64'hAA);
        chk("w_rs1",   64'(exe_rs1),   64'hBB);
        cpu_abort_req = 1'b1;
        tick();
        cpu_abort_req = 1'b0;
        chk("w_flush", 64'(buf_count), 64'd0);

        // Back-to-back responses, one per cycle
        cpu_insn_ack  = 1'b1;
        exe_rsp_valid = 1'b1;
        exe_wen       = 1'b1;
        exe_result    = 3'd0;
        for (int i = 0; i < 4; i++) begin
            exe_waddr = 5'(i);
            exe_wdata = 32'h10 + 32'(i);
            #1;
            chk("b_ready", 64'(exe_rsp_ready), 64'd1);
            tick();
            chk("b_rsp",   64'(cop_insn_rsp), 64'd1);
            chk("b_wdata", 64'(cop_wdata),    64'h10 + 64'(i));
            chk("b_waddr", 64'(cop_waddr),    64'(i));
        end
        exe_rsp_valid = 1'b0;
        tick();
        cpu_insn_ack = 1'b0;
        chk("b_rsp_end", 64'(cop_insn_rsp), 64'd0);

        // Simultaneous push and issue, then reset mid-operation
        cpu_insn_req = 1'b1;
        cpu_insn_enc = 32'h200;
        tick();
        cpu_insn_enc = 32'h201;
        tick();
        chk("s_count2", 64'(buf_count), 64'd2);
        cpu_insn_enc = 32'h202;
        exe_ready    = 1'b1;
        tick();
        cpu_insn_req = 1'b0;
        exe_ready    = 1'b0;
        chk("s_count_same", 64'(buf_count), 64'd2);
        chk("s_head",       64'(exe_insn),  64'h201);
        exe_rsp_valid = 1'b1;
        exe_wen       = 1'b1;
        exe_waddr     = 5'd9;
        exe_wdata     = 32'h5555_5555;
        exe_result    = 3'd4;
        tick();
        exe_rsp_valid = 1'b0;
        chk("r_rsp_pre",   64'(cop_insn_rsp), 64'd1);
        chk("r_count_pre", 64'(buf_count),    64'd2);
        g_reset = 1'b1;
        tick();
        chk("r_rsp",    64'(cop_insn_rsp), 64'd0);
        chk("r_wen",    64'(cop_wen),      64'd0);
        chk("r_waddr",  64'(cop_waddr),    64'd0);
        chk("r_wdata",  64'(cop_wdata),    64'd0);
        chk("r_result", 64'(cop_result),   64'd0);
        chk("r_valid",  64'(exe_valid),    64'd0);
        chk("r_count",  64'(buf_count),    64'd0);
        chk("r_busy",   64'(cop_busy),     64'd0);
        chk("r_ack",    64'(cop_insn_ack), 64'd0);
        g_reset = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
